// File: rtl/repdigit_series_engine_pkg.sv
// Shared definitions for the repdigit series engine: FSM encoding, default
// widths and the 10^k+1 multiplier constant.
package solver_pkg;

    localparam int X_W_DEF     = 40;
    localparam int ACC_W_DEF   = 64;
    localparam int CHUNK_W_DEF = 16;
    localparam int K_MAX_DEF   = 12;
    localparam int KC_W        = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
        S_MUL3 = 3'd4,
        S_MUL4 = 3'd5,
        S_ACC  = 3'd6,
        S_OUT  = 3'd7
    } state_e;

    // 10^k+1; out-of-range k yields 1 (those entries are skipped anyway).
    function automatic logic [KC_W-1:0] k_const(input int unsigned k, input int unsigned k_max);
        logic [KC_W-1:0] p;
        p = 64'd1;
        if ((k == 32'd0) || (k > k_max)) begin
            p = 64'd1;
        end else begin
            for (int unsigned i = 32'd1; i <= 32'd19; i++) begin
                if (i <= k) begin
                    p = p * 64'd10;
                end else begin
                    p = p;
                end
            end
            p = p + 64'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/repdigit_series_engine_chunk_addsub.sv
// Chunk-serial unit producing x_start+x_end and x_end-x_start+1, one chunk per
// enabled cycle, with carry (add) and borrow-style carry (sub) held in flops.
module chunk_addsub #(
    parameter int X_W     = 40,
    parameter int CHUNK_W = 16,
    parameter int NCHUNK  = (X_W + CHUNK_W - 1) / CHUNK_W,
    parameter int PW      = NCHUNK * CHUNK_W,
    parameter int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    input  logic [X_W-1:0]   a,
    input  logic [X_W-1:0]   b,
    output logic [PW:0]      sum_o,
    output logic [PW:0]      cnt_o
);

    logic [PW-1:0]      a_pad_s, b_pad_s;
    logic [CHUNK_W-1:0] a_c_s, b_c_s;
    logic [CHUNK_W:0]   s_full_s;
    logic [CHUNK_W+1:0] d_full_s;
    logic [PW-1:0]      sum_d, sum_q, cnt_d, cnt_q;
    logic               add_c_d, add_c_q;
    logic [1:0]         sub_c_d, sub_c_q;

    // b + ~a + 2 == b - a + 1 (mod 2^PW); the 2-bit carry absorbs the +2.
    always_comb begin
        a_pad_s  = PW'(a);
        b_pad_s  = PW'(b);
        a_c_s    = a_pad_s[idx*CHUNK_W +: CHUNK_W];
        b_c_s    = b_pad_s[idx*CHUNK_W +: CHUNK_W];
        s_full_s = {1'b0, b_c_s} + {1'b0, a_c_s} + (CHUNK_W+1)'(add_c_q);
        d_full_s = {2'b00, b_c_s} + {2'b00, ~a_c_s} + (CHUNK_W+2)'(sub_c_q);
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        add_c_d  = add_c_q;
        sub_c_d  = sub_c_q;
        if (clr) begin
            add_c_d = 1'b0;
            sub_c_d = 2'd2;
        end else if (en) begin
            sum_d[idx*CHUNK_W +: CHUNK_W] = s_full_s[CHUNK_W-1:0];
            cnt_d[idx*CHUNK_W +: CHUNK_W] = d_full_s[CHUNK_W-1:0];
            add_c_d = s_full_s[CHUNK_W];
            sub_c_d = d_full_s[CHUNK_W+1:CHUNK_W];
        end else begin
            add_c_d = add_c_q;
            sub_c_d = sub_c_q;
        end
    end

    // Chunk result and carry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            add_c_q <= 1'b0;
            sub_c_q <= 2'd2;
        end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            add_c_q <= add_c_d;
            sub_c_q <= sub_c_d;
        end
    end

    // Final sub carry is 2 only when the count equals 2^PW.
    assign sum_o = {add_c_q, sum_q};
    assign cnt_o = {sub_c_q[1], cnt_q};

endmodule

// File: rtl/repdigit_series_engine.sv
// Accumulates (x_start+x_end)*(x_end-x_start+1)/2 * (10^k+1) over a batch of
// entries and hands the modular sum out with sticky overflow / k-error flags.
module repdigit_series_engine
    import solver_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int K_MAX   = K_MAX_DEF,
    parameter int K_W     = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x_start,
    input  logic [X_W-1:0]   in_x_end,
    input  logic [K_W-1:0]   in_k,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             overflow,
    output logic             k_err
);

    localparam int NCHUNK = (X_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PW     = NCHUNK * CHUNK_W;
    localparam int OP_W   = PW + 1;
    localparam int P1_W   = 2 * OP_W;
    localparam int P2_W   = P1_W + KC_W;
    localparam int CI_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e            state_d, state_q;
    logic [X_W-1:0]    xs_d, xs_q, xe_d, xe_q;
    logic [K_W-1:0]    k_d, k_q;
    logic              last_d, last_q;
    logic [CI_W-1:0]   chunk_d, chunk_q;
    logic [KC_W-1:0]   kc_d, kc_q;
    logic [P1_W-1:0]   p1_d, p1_q, p1b_d, p1b_q;
    logic [P2_W-1:0]   p2_d, p2_q, p2b_d, p2b_q;
    logic [P2_W-1:0]   half_s;
    logic [ACC_W:0]    add_s;
    logic [ACC_W-1:0]  acc_d, acc_q;
    logic              ovf_d, ovf_q, kerr_d, kerr_q;
    logic              in_ready_d, in_ready_q, out_valid_d, out_valid_q;
    logic              clr_s, en_s, k_bad_s;
    logic [OP_W-1:0]   sum_s, cnt_s;

    chunk_addsub #(.X_W(X_W), .CHUNK_W(CHUNK_W)) u_addsub (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .en    (en_s),
        .idx   (chunk_q),
        .a     (xs_q),
        .b     (xe_q),
        .sum_o (sum_s),
        .cnt_o (cnt_s)
    );

    // Next-state, datapath stage selection and flag updates.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        k_d     = k_q;
        last_d  = last_q;
        chunk_d = chunk_q;
        kc_d    = kc_q;
        p1_d    = p1_q;
        p1b_d   = p1b_q;
        p2_d    = p2_q;
        p2b_d   = p2b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        kerr_d  = kerr_q;
        clr_s   = 1'b0;
        en_s    = 1'b0;
        k_bad_s = (in_k == {K_W{1'b0}}) || (int'(in_k) > K_MAX);
        half_s  = p2b_q >> 1;
        add_s   = {1'b0, acc_q} + {1'b0, half_s[ACC_W-1:0]};
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    xs_d    = in_x_start;
                    xe_d    = in_x_end;
                    k_d     = in_k;
                    last_d  = in_last;
                    chunk_d = {CI_W{1'b0}};
                    clr_s   = 1'b1;
                    kerr_d  = kerr_q | k_bad_s;
                    if (k_bad_s || (in_x_end < in_x_start)) begin
                        state_d = in_last ? S_OUT : S_IDLE;
                    end else begin
                        state_d = S_ADD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                en_s = 1'b1;
                if (chunk_q == CI_W'(NCHUNK - 1)) begin
                    state_d = S_MUL1;
                end else begin
                    chunk_d = chunk_q + CI_W'(1);
                end
            end
            S_MUL1: begin
                p1_d    = P1_W'(sum_s) * P1_W'(cnt_s);
                kc_d    = k_const(32'(k_q), K_MAX);
                state_d = S_MUL2;
            end
            S_MUL2: begin
                p1b_d   = p1_q;
                state_d = S_MUL3;
            end
            S_MUL3: begin
                p2_d    = P2_W'(p1b_q) * P2_W'(kc_q);
                state_d = S_MUL4;
            end
            S_MUL4: begin
                p2b_d   = p2_q;
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_d   = add_s[ACC_W-1:0];
                ovf_d   = ovf_q | (|half_s[P2_W-1:ACC_W]) | add_s[ACC_W];
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = {ACC_W{1'b0}};
                    ovf_d   = 1'b0;
                    kerr_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
    end

    // Control state, accumulator and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            kerr_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            chunk_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            kerr_q      <= kerr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            chunk_q     <= chunk_d;
        end
    end

    // Operand and multiplier pipeline registers.
    always_ff @(posedge clk) begin
        xs_q   <= xs_d;
        xe_q   <= xe_d;
        k_q    <= k_d;
        last_q <= last_d;
        kc_q   <= kc_d;
        p1_q   <= p1_d;
        p1b_q  <= p1b_d;
        p2_q   <= p2_d;
        p2b_q  <= p2b_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_out   = acc_q;
    assign overflow  = ovf_q;
    assign k_err     = kerr_q;

endmodule

// File: doc/repdigit_series_engine.md
REPDIGIT_SERIES_ENGINE -- requirements
Module: repdigit_series_engine

Interface
REQ-001 SHALL take parameter X_W, default 40, the operand width of x_start/x_end.
REQ-002 SHALL take parameter ACC_W, default 64, the accumulator and result width.
REQ-003 SHALL take parameter CHUNK_W, default 16, the chunk width for carry-registered add/sub; NCHUNK = ceil(X_W/CHUNK_W).
REQ-004 SHALL take parameter K_MAX, default 12, the largest supported K; K_W = clog2(K_MAX+1).
REQ-005 SHALL have ports clk (in, 1, single clock) and rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have ports in_valid (in, 1) and in_ready (out, 1): entry handshake.
REQ-007 SHALL have ports in_x_start (in, X_W), in_x_end (in, X_W) and in_k (in, K_W): inclusive range and repeat factor.
REQ-008 SHALL have port in_last (in, 1): marks the final entry of a batch.
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1) and sum_out (out, ACC_W): batch result handshake.
REQ-010 SHALL have ports overflow (out, 1) and k_err (out, 1): sticky batch flags, valid while out_valid=1.

Function
REQ-011 SHALL compute per accepted entry contribution C = (x_start+x_end)*(x_end-x_start+1)/2 * (10^k + 1).
REQ-012 The divide by 2 SHALL be an exact right shift, because the product is always even.
REQ-013 SHALL accumulate C into acc modulo 2^ACC_W over every entry of a batch.
REQ-014 FSM states SHALL be S_IDLE, S_ADD, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_ACC and S_OUT.
REQ-015 in_ready SHALL be 1 only in S_IDLE; an entry is accepted on a cycle with in_valid & in_ready.
REQ-016 On acceptance, S_IDLE SHALL register the inputs and go to S_ADD.
REQ-017 S_ADD SHALL last exactly NCHUNK cycles, computing one chunk per cycle of sum = x_start+x_end and count = x_end-x_start+1 in parallel, with carry/borrow registered between chunks.
REQ-018 S_MUL1 SHALL form sum*count; S_MUL2 is a register stage; S_MUL3 SHALL multiply by the K constant; S_MUL4 is a register stage.
REQ-019 S_ACC SHALL add (product>>1) into acc, then go to S_OUT if last was set, else to S_IDLE.
REQ-020 Latency SHALL be NCHUNK+6 cycles from acceptance to the next in_ready or out_valid (9 cycles at defaults).
REQ-021 An entry with x_end < x_start SHALL contribute 0 and go from S_IDLE directly to S_OUT/S_IDLE on the next cycle.
REQ-022 An entry with in_k = 0 or in_k > K_MAX SHALL contribute 0, set k_err, and take the same skip path.
REQ-023 overflow SHALL set if any bit of (product>>1) at or above ACC_W is nonzero, or if the acc addition carries out.
REQ-024 In S_OUT, out_valid SHALL be 1 and sum_out, overflow and k_err SHALL be held stable until out_ready=1.
REQ-025 On the S_OUT handshake cycle, acc, overflow and k_err SHALL clear and the FSM SHALL return to S_IDLE.
REQ-026 in_last on a skipped entry SHALL still close the batch; a batch of only skipped entries yields sum_out=0.

Reset
REQ-027 While rst=1 at a clock edge: state <= S_IDLE, acc = 0, out_valid = 0, overflow = 0, k_err = 0, sum_out = 0.
REQ-028 in_ready SHALL be 0 during reset and 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-entry or mid-S_OUT SHALL discard all in-flight work, with no partial accumulation surviving.

Structure
REQ-030 Package solver_pkg SHALL hold the state encoding, default widths and the function k_const(k) = 10^k+1 (returning 1 for out-of-range k).
REQ-031 The chunk-serial adder/subtractor SHALL be one sub-module, chunk_addsub, parametrised by X_W and CHUNK_W.
REQ-032 The multiplies SHALL be registered stages suitable for DSP inference; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-033 Entry (1,9,k=1,last) -> after 9 cycles out_valid=1, sum_out=495, overflow=0, k_err=0.
REQ-034 Entries (10,99,k=2) then (1,9,k=1,last) -> sum_out=495900.
REQ-035 Entries (50,20,k=3,last) and (5,5,k=0,last) as separate batches -> sum_out=0 for both, k_err=0 then k_err=1, each out_valid 1 cycle after acceptance.
REQ-036 With out_ready held low for 5 cycles -> out_valid and sum_out stable, in_ready=0; handshake, then next cycle in_ready=1 and new batch starts from 0.
REQ-037 With ACC_W=16, entry (10,99,k=2,last) -> sum_out=36653, overflow=1.
REQ-038 With rst asserted during S_MUL2 of the first entry -> next cycle in_ready=1, out_valid=0; a following batch (1,9,k=1,last) gives 495.
